dsp_mac: RTL

DSP_MAC -- requirements
Module: dsp_mac

---
 rtl/dsp_mac_pkg.sv | 26 ++
 rtl/dsp_mac_if.sv | 32 +++
 rtl/mul_round_sat.sv | 44 ++++
 rtl/dsp_mac.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared constants, FSM state encoding and saturation-limit helpers for the
// dsp_mac dot-product engine (signed Q15.16 by default).
package dsp_mac_pkg;

  localparam int unsigned DSP_NB_DATA  = 32;
  localparam int unsigned DSP_NBF_DATA = 16;
  localparam int unsigned DSP_NB_LEN   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Largest positive two's-complement value of an nb-bit word (nb <= 64).
  function automatic logic [63:0] sat_pos(input int unsigned nb);
    return (64'd1 << (nb - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of an nb-bit word (nb <= 64).
  function automatic logic [63:0] sat_neg(input int unsigned nb);
    return 64'd1 << (nb - 1);
  endfunction

endpackage

// File: rtl/dsp_mac_if.sv
// Operand/result bus of dsp_mac.
//   master : drives i_start, i_len, i_valid, i_a, i_b; observes the outputs
//   slave  : the MAC engine side
interface dsp_mac_if
  import dsp_mac_pkg::*;
#(
  parameter int unsigned NB_DATA = DSP_NB_DATA,
  parameter int unsigned NB_LEN  = DSP_NB_LEN
) ();

  logic               i_start;
  logic [NB_LEN-1:0]  i_len;
  logic               i_valid;
  logic [NB_DATA-1:0] i_a;
  logic [NB_DATA-1:0] i_b;
  logic               o_ready;
  logic [NB_DATA-1:0] o_result;
  logic               o_done;
  logic               o_busy;
  logic               o_ovf;

  modport master (
    output i_start, i_len, i_valid, i_a, i_b,
    input  o_ready, o_result, o_done, o_busy, o_ovf
  );

  modport slave (
    input  i_start, i_len, i_valid, i_a, i_b,
    output o_ready, o_result, o_done, o_busy, o_ovf
  );

endinterface

// File: rtl/mul_round_sat.sv
// Combinational round-and-saturate of a 2*NB_DATA-bit signed product down to
// NB_DATA bits: add half an LSB, arithmetic shift by NBF_DATA (round half
// toward +inf), clamp to the signed NB_DATA range.
//   prod : full-width signed product
//   res  : rounded, saturated result
//   sat  : high when res was clamped
module mul_round_sat
  import dsp_mac_pkg::*;
#(
  parameter int unsigned NB_DATA  = DSP_NB_DATA,
  parameter int unsigned NBF_DATA = DSP_NBF_DATA
) (
  input  logic [2*NB_DATA-1:0] prod,
  output logic [NB_DATA-1:0]   res,
  output logic                 sat
);

  localparam int unsigned NB_PROD = 2 * NB_DATA;
  localparam int unsigned NB_EXT  = NB_PROD + 1;
  localparam int unsigned NB_HI   = NB_EXT - NB_DATA + 1;
  localparam logic [NB_EXT-1:0]  HALF    = NB_EXT'(1) << (NBF_DATA - 1);
  localparam logic [NB_DATA-1:0] SAT_POS = NB_DATA'(sat_pos(NB_DATA));
  localparam logic [NB_DATA-1:0] SAT_NEG = NB_DATA'(sat_neg(NB_DATA));

  logic signed [NB_EXT-1:0] rounded;
  logic signed [NB_EXT-1:0] shifted;
  logic [NB_HI-1:0]         hi;

  // One guard bit keeps the half-LSB add from wrapping.
  assign rounded = $signed({prod[NB_PROD-1], prod} + HALF);
  assign shifted = rounded >>> NBF_DATA;
  // Value fits when everything from the result sign bit upward is a sign copy.
  assign hi      = shifted[NB_EXT-1 -: NB_HI];

  always_comb begin
    res = shifted[NB_DATA-1:0];
    sat = 1'b0;
    if ((hi != '0) && (hi != '1)) begin
      sat = 1'b1;
      res = hi[NB_HI-1] ? SAT_NEG : SAT_POS;
    end
  end

endmodule

// File: rtl/dsp_mac.sv
// Saturating signed fixed-point dot-product engine.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of dsp_mac_if
//     i_start/i_len start an operation of i_len pairs (sampled in IDLE only)
//     i_valid/o_ready handshake each (i_a, i_b) pair (o_ready high in RUN)
//     o_result holds the saturated accumulator, o_ovf flags any clamp,
//     o_done pulses once the final pair has been accumulated, o_busy = !IDLE
module dsp_mac
  import dsp_mac_pkg::*;
#(
  parameter int unsigned NB_DATA  = DSP_NB_DATA,
  parameter int unsigned NBF_DATA = DSP_NBF_DATA,
  parameter int unsigned NB_LEN   = DSP_NB_LEN
) (
  input logic     clk,
  input logic     rst,
  dsp_mac_if.slave bus
);

  localparam int unsigned NB_PROD = 2 * NB_DATA;
  localparam logic [NB_DATA-1:0] SAT_POS = NB_DATA'(sat_pos(NB_DATA));
  localparam logic [NB_DATA-1:0] SAT_NEG = NB_DATA'(sat_neg(NB_DATA));

  state_t               state;
  logic [NB_LEN-1:0]    len_q;
  logic [NB_LEN-1:0]    cnt;
  logic [NB_PROD-1:0]   prod_q;
  logic                 p1_valid;
  logic [NB_DATA-1:0]   acc;
  logic                 ovf;
  logic                 ready;
  logic                 done;
  logic                 busy;

  logic signed [NB_DATA-1:0] a_s;
  logic signed [NB_DATA-1:0] b_s;
  logic signed [NB_PROD-1:0] prod_c;
  logic                      accept_c;
  logic [NB_LEN-1:0]         cnt_inc_c;
  logic [NB_DATA-1:0]        rnd_c;
  logic                      sat_c;
  logic [NB_DATA:0]          sum_c;
  logic                      acc_ovf_c;
  logic [NB_DATA-1:0]        acc_next_c;

  assign a_s       = bus.i_a;
  assign b_s       = bus.i_b;
  assign prod_c    = NB_PROD'(a_s) * NB_PROD'(b_s);
  assign accept_c  = (state == ST_RUN) && ready && bus.i_valid;
  assign cnt_inc_c = cnt + NB_LEN'(1);

  mul_round_sat #(
    .NB_DATA  (NB_DATA),
    .NBF_DATA (NBF_DATA)
  ) u_round (
    .prod (prod_q),
    .res  (rnd_c),
    .sat  (sat_c)
  );

  // Sign-extended accumulate; differing top bits mean the sum left the range.
  assign sum_c      = {acc[NB_DATA-1], acc} + {rnd_c[NB_DATA-1], rnd_c};
  assign acc_ovf_c  = sum_c[NB_DATA] ^ sum_c[NB_DATA-1];
  assign acc_next_c = acc_ovf_c ? (sum_c[NB_DATA] ? SAT_NEG : SAT_POS)
                                : sum_c[NB_DATA-1:0];

  // Control FSM plus the two-stage multiply / accumulate pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      cnt      <= '0;
      prod_q   <= '0;
      p1_valid <= 1'b0;
      acc      <= '0;
      ovf      <= 1'b0;
      ready    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done     <= 1'b0;
      p1_valid <= accept_c;
      if (accept_c) prod_q <= prod_c;
      if (p1_valid) begin
        acc <= acc_next_c;
        if (sat_c || acc_ovf_c) ovf <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            len_q <= bus.i_len;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            if (bus.i_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              ready <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept_c) begin
            cnt <= cnt_inc_c;
            if (cnt_inc_c == len_q) begin
              state <= ST_DRAIN;
              ready <= 1'b0;
            end
          end
        end
        // Stage 1 empty means stage 2 has taken the last product.
        ST_DRAIN: begin
          if (!p1_valid) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_result = acc;
  assign bus.o_done   = done;
  assign bus.o_busy   = busy;
  assign bus.o_ovf    = ovf;

endmodule
